muldiv_hilo: RTL and testbench

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo_pkg.sv | 17 +
 rtl/muldiv_hilo_div_iter.sv | 40 ++++
 rtl/muldiv_hilo.sv | 77 +++++++
 tb/tb_muldiv_hilo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_pkg.sv
// muldiv_hilo_pkg: shared FSM encoding, request bit positions and helpers for the HI/LO unit
package muldiv_hilo_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam int MULT_S  = 0;
    localparam int MULT_U  = 1;
    localparam int DIV_S   = 0;
    localparam int DIV_U   = 1;
    localparam int MTHL_LO = 0;
    localparam int MTHL_HI = 1;
    localparam int MFHL_LO = 0;
    localparam int MFHL_HI = 1;
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// div_iter: unsigned restoring radix-2 divider, one quotient bit per step, 32 steps
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         done
);
    logic [W-1:0] dvs;
    logic [4:0]   cnt;
    logic [W:0]   sh;
    logic         ge;
    assign sh   = {rem, quo[W-1]};
    assign ge   = sh >= {1'b0, dvs};
    assign done = step && cnt == 5'd31;
    // load operands on start, then shift-compare-subtract once per step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            quo <= a;
            rem <= '0;
            dvs <= b;
            cnt <= '0;
        end else if (step) begin
            quo <= {quo[W-2:0], ge};
            rem <= ge ? sh[W-1:0] - dvs : sh[W-1:0];
            cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO register file with single-cycle multiply, moves and a 34-cycle divider
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        MULT,
    input  logic [1:0]        DIV,
    input  logic [1:0]        MTHL,
    input  logic [1:0]        MFHL,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    input  logic              cancel,
    output logic              busy,
    output logic [DATA_W-1:0] hl_rdata
);
    logic [1:0]          state;
    logic [DATA_W-1:0]   hi, lo, a_raw, quo, rem;
    logic                sa, sb, bz, done, start, step, div_signed, neg_a, neg_b, mult_req;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    assign div_signed = DIV[DIV_S] & ~DIV[DIV_U];
    assign neg_a      = div_signed & rs_value[DATA_W-1];
    assign neg_b      = div_signed & rt_value[DATA_W-1];
    assign mult_req   = MULT[MULT_S] | MULT[MULT_U];
    assign start      = state == ST_IDLE && !cancel && |DIV;
    assign step       = state == ST_CALC && !cancel;
    assign busy       = state != ST_IDLE;
    assign hl_rdata   = MFHL[MFHL_HI] ? hi : MFHL[MFHL_LO] ? lo : '0;
    assign prod_u     = {{DATA_W{1'b0}}, rs_value} * {{DATA_W{1'b0}}, rt_value};
    assign prod_s     = {{DATA_W{rs_value[DATA_W-1]}}, rs_value} * {{DATA_W{rt_value[DATA_W-1]}}, rt_value};
    div_iter #(.W(DATA_W)) u_div (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .step  (step),
        .a     (neg_if(rs_value, neg_a)),
        .b     (neg_if(rt_value, neg_b)),
        .quo   (quo),
        .rem   (rem),
        .done  (done)
    );
    // issue requests in IDLE, sequence the divide and sign-correct its result in FIX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            bz    <= 1'b0;
            a_raw <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state <= ST_CALC;
                sa    <= neg_a;
                sb    <= neg_b;
                bz    <= rt_value == '0;
                a_raw <= rs_value;
            end else if (!cancel && mult_req) begin
                {hi, lo} <= MULT[MULT_U] ? prod_u : prod_s;
            end else if (!cancel) begin
                if (MTHL[MTHL_HI]) hi <= rs_value;
                if (MTHL[MTHL_LO]) lo <= rs_value;
            end
        end else if (state == ST_CALC) begin
            state <= cancel ? ST_IDLE : done ? ST_FIX : ST_CALC;
        end else begin
            state <= ST_IDLE;
            if (!cancel) begin
                hi <= bz ? a_raw : neg_if(rem, sa);
                lo <= bz ? '1 : neg_if(quo, sa ^ sb);
            end
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: vector table, corner sequences and randomized ops against an arithmetic model
module tb_muldiv_hilo;
    logic        clk = 0, resetn = 1, cancel = 0;
    logic [1:0]  MULT = 0, DIV = 0, MTHL = 0, MFHL = 0;
    logic [31:0] rs_value = 0, rt_value = 0;
    logic        busy;
    logic [31:0] hl_rdata;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] mhi = 0, mlo = 0, h, l;
    logic [63:0] exp_hl;

    typedef struct {
        logic [1:0]  m, d, t;
        logic [31:0] a, b, eh, el;
    } vec_t;
    vec_t tbl[12];

    muldiv_hilo #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .MULT(MULT), .DIV(DIV), .MTHL(MTHL), .MFHL(MFHL),
        .rs_value(rs_value), .rt_value(rt_value), .cancel(cancel), .busy(busy), .hl_rdata(hl_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] rh, output logic [31:0] rl);
        MFHL = 2'b10;
        #1 rh = hl_rdata;
        MFHL = 2'b01;
        #1 rl = hl_rdata;
        MFHL = 2'b00;
    endtask

    function automatic logic [63:0] model(input logic [1:0] m, input logic [1:0] d, input logic [1:0] t,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] oh, input logic [31:0] ol);
        logic [63:0]        r;
        logic signed [31:0] x, y;
        r = {oh, ol};
        if (d != 0) begin
            x = a;
            y = b;
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else if (d[1]) r = {a % b, a / b};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else r = {32'(x % y), 32'(x / y)};
        end else if (m != 0) begin
            if (m[1]) r = 64'(a) * 64'(b);
            else r = longint'($signed(a)) * longint'($signed(b));
        end else begin
            if (t[1]) r[63:32] = a;
            if (t[0]) r[31:0] = a;
        end
        return r;
    endfunction

    task automatic do_op(input logic [1:0] m, input logic [1:0] d, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] b, input string nm,
                         output logic [31:0] oh, output logic [31:0] ol);
        int bc, dc;
        @(negedge clk);
        MULT = m; DIV = d; MTHL = t; rs_value = a; rt_value = b;
        @(posedge clk);
        #1 MULT = 0; DIV = 0; MTHL = 0;
        if (d != 0) begin
            bc = 0;
            dc = 0;
            for (int c = 1; c <= 40 && dc == 0; c++) begin
                @(negedge clk);
                if (busy) bc++;
                else dc = c;
            end
            check({nm, " busy_cycles"}, 64'(bc), 64'd33);
            check({nm, " done_cycle"}, 64'(dc), 64'd34);
        end else begin
            @(negedge clk);
            check({nm, " busy"}, {63'd0, busy}, 64'd0);
        end
        read_hl(oh, ol);
    endtask

    initial begin
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{2'b10, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        tbl[2]  = '{2'b11, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        tbl[3]  = '{2'b00, 2'b01, 2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4]  = '{2'b00, 2'b10, 2'b00, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        tbl[5]  = '{2'b00, 2'b01, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[6]  = '{2'b00, 2'b01, 2'b00, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        tbl[7]  = '{2'b00, 2'b10, 2'b00, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        tbl[8]  = '{2'b00, 2'b01, 2'b00, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        tbl[9]  = '{2'b00, 2'b00, 2'b11, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF};
        tbl[10] = '{2'b01, 2'b01, 2'b00, 32'd20,       32'd3,        32'h00000002, 32'h00000006};
        tbl[11] = '{2'b01, 2'b00, 2'b11, 32'd5,        32'd5,        32'h00000000, 32'h00000019};

        #3 resetn = 0;
        #1 check("reset_async busy", {63'd0, busy}, 64'd0);
        read_hl(h, l);
        check("reset_async hilo", {h, l}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].m, tbl[i].d, tbl[i].t, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), h, l);
            check($sformatf("vec%0d hi", i), {32'd0, h}, {32'd0, tbl[i].eh});
            check($sformatf("vec%0d lo", i), {32'd0, l}, {32'd0, tbl[i].el});
        end
        MFHL = 2'b00;
        #1 check("mfhl none", {32'd0, hl_rdata}, 64'd0);
        MFHL = 2'b11;
        #1 check("mfhl both", {32'd0, hl_rdata}, 64'd0);

        @(negedge clk);
        MTHL = 2'b11; rs_value = 32'h1111;
        @(posedge clk);
        #1 MTHL = 0;
        @(negedge clk);
        MTHL = 2'b10; rs_value = 32'h1234; MFHL = 2'b10;
        #1 check("mthi no_forward", {32'd0, hl_rdata}, 64'h1111);
        @(posedge clk);
        #1 MTHL = 0;
        check("mthi hi", {32'd0, hl_rdata}, 64'h1234);
        MFHL = 2'b01;
        #1 check("mthi old_lo", {32'd0, hl_rdata}, 64'h1111);
        MFHL = 2'b00;

        @(negedge clk);
        MTHL = 2'b11; rs_value = 32'h5;
        @(posedge clk);
        #1 MTHL = 0;
        @(negedge clk);
        DIV = 2'b01; rs_value = 32'd100; rt_value = 32'd3;
        @(posedge clk);
        #1 DIV = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c >= 2) begin
                MULT = 2'b01; rs_value = 32'd7; rt_value = 32'd7;
            end
            @(posedge clk);
            #1;
        end
        MULT = 0; cancel = 1;
        @(negedge clk);
        check("calc_cancel busy_c10", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1 cancel = 0;
        @(negedge clk);
        check("calc_cancel busy_c11", {63'd0, busy}, 64'd0);
        read_hl(h, l);
        check("calc_cancel hilo", {h, l}, {32'h5, 32'h5});
        repeat (30) @(negedge clk);
        read_hl(h, l);
        check("calc_cancel hilo_late", {h, l}, {32'h5, 32'h5});

        @(negedge clk);
        DIV = 2'b01; rs_value = 32'd100; rt_value = 32'd3;
        @(posedge clk);
        #1 DIV = 0;
        repeat (32) @(posedge clk);
        #1 cancel = 1;
        @(negedge clk);
        check("fix_cancel busy_c33", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1 cancel = 0;
        @(negedge clk);
        check("fix_cancel busy_c34", {63'd0, busy}, 64'd0);
        read_hl(h, l);
        check("fix_cancel hilo", {h, l}, {32'h5, 32'h5});

        @(negedge clk);
        DIV = 2'b01; cancel = 1; rs_value = 32'd100; rt_value = 32'd3;
        @(posedge clk);
        #1 DIV = 0; cancel = 0;
        @(negedge clk);
        check("idle_cancel div busy", {63'd0, busy}, 64'd0);
        MTHL = 2'b11; cancel = 1; rs_value = 32'h9;
        @(posedge clk);
        #1 MTHL = 0; cancel = 0;
        @(negedge clk);
        read_hl(h, l);
        check("idle_cancel mthl hilo", {h, l}, {32'h5, 32'h5});

        @(negedge clk);
        DIV = 2'b01; rs_value = 32'd100; rt_value = 32'd3;
        @(posedge clk);
        #1 DIV = 0;
        repeat (19) @(posedge clk);
        #2 resetn = 0;
        #1 check("mid_reset busy", {63'd0, busy}, 64'd0);
        read_hl(h, l);
        check("mid_reset hilo", {h, l}, 64'd0);
        @(negedge clk);
        resetn = 1;
        do_op(2'b00, 2'b01, 2'b00, 32'd1000, 32'd7, "post_reset div", h, l);
        check("post_reset div hilo", {h, l}, {32'd6, 32'd142});
        mhi = 32'd6;
        mlo = 32'd142;

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  m, d, t;
            logic [31:0] a, b;
            int          k;
            k = $urandom_range(0, 4);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 6) == 0) b = 0;
            m = 0; d = 0; t = 0;
            case (k)
                0: begin m = 2'b01; t = 2'($urandom_range(0, 3)); end
                1: begin m = 2'b10; t = 2'($urandom_range(0, 3)); end
                2: begin d = 2'b01; m = 2'($urandom_range(0, 3)); end
                3: begin d = 2'b10; m = 2'($urandom_range(0, 3)); end
                default: t = 2'($urandom_range(1, 3));
            endcase
            exp_hl = model(m, d, t, a, b, mhi, mlo);
            do_op(m, d, t, a, b, $sformatf("rand%0d", i), h, l);
            check($sformatf("rand%0d hilo", i), {h, l}, exp_hl);
            {mhi, mlo} = exp_hl;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
